// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared types and defaults for the flash bus arbiter.
// Holds the FSM states, one-hot grant codes and default bus widths.
package flash_arb_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/flash_arb_timer.sv
// flash_arb_timer: 16-bit watchdog counter for a flash transaction.
// expire is high while the count sits at TIMEOUT_CYC-1.
module flash_arb_timer
  import flash_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] count;

  // count busy cycles, restarting on every new grant
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 16'd1;
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/flash_bus_arbiter.sv
// flash_bus_arbiter: shares one flash slave between CPU (m0) and loader (m1).
// Define ARB_RR_EN for round-robin ties; otherwise m0 has fixed priority.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                TIMEOUT_CYC = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(DEF_ERR_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m0_select_i,
  input  logic              m0_we_i,
  output logic              m0_ack_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  input  logic              m1_select_i,
  input  logic              m1_we_i,
  output logic              m1_ack_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_select_o,
  output logic              s_we_o,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  arb_state_t state, state_d;
  logic owner;
  logic req_win;
  logic grant_now;
  logic done_ack;
  logic done_to;
  logic expire;

`ifdef ARB_RR_EN
  logic last_owner;
`endif

  flash_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant_now),
    .en    (state == BUSY),
    .expire(expire)
  );

  // pick the master that wins an IDLE request (1 = m1)
  always_comb begin
`ifdef ARB_RR_EN
    if (m0_select_i && m1_select_i) req_win = ~last_owner;
    else                            req_win = m1_select_i;
`else
    req_win = m1_select_i && !m0_select_i;
`endif
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next state and transaction strobes; ack beats expiry
  always_comb begin
    state_d   = state;
    grant_now = 1'b0;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_select_i || m1_select_i) begin
          grant_now = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          done_ack = 1'b1;
          state_d  = ACK;
        end else if (expire) begin
          done_to = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // registered bus request, routed read data and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      grant_o    <= GNT_NONE;
      s_select_o <= 1'b0;
      s_addr_o   <= '0;
      s_data_o   <= '0;
      s_we_o     <= 1'b0;
      m0_data_o  <= '0;
      m1_data_o  <= '0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      timeout_o <= 1'b0;
      if (grant_now) begin
        owner      <= req_win;
        grant_o    <= req_win ? GNT_M1 : GNT_M0;
        s_select_o <= 1'b1;
        s_addr_o   <= req_win ? m1_addr_i : m0_addr_i;
        s_data_o   <= req_win ? m1_data_i : m0_data_i;
        s_we_o     <= req_win ? m1_we_i : m0_we_i;
      end
      if (done_ack || done_to) begin
        s_select_o <= 1'b0;
        timeout_o  <= done_to;
        if (owner) m1_data_o <= done_ack ? s_data_i : ERR_DATA;
        else       m0_data_o <= done_ack ? s_data_i : ERR_DATA;
      end
      if (state == ACK) begin
        m0_ack_o <= ~owner;
        m1_ack_o <= owner;
      end
      if (state == GAP) grant_o <= GNT_NONE;
    end
  end

`ifdef ARB_RR_EN
  // remember who was served last so the other side wins the next tie
  always_ff @(posedge clk) begin
    if (rst)               last_owner <= 1'b1;
    else if (state == GAP) last_owner <= owner;
  end
`endif

endmodule
